// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution stage.
package branch_pkg;
  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} br_state_t;
  localparam int PC_INC = 4;
endpackage

// File: rtl/branch_resolve_if.sv
// Issue / comparator / redirect / statistics bundle for branch_resolve.
interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             issue_valid;
  logic             issue_ready;
  logic [XLEN-1:0]  issue_pc;
  logic [XLEN-1:0]  issue_target;
  logic             issue_is_jump;
  logic             issue_pred_taken;
  logic             cmp_result;
  logic             flush;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             resolved_valid;
  logic             resolved_taken;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output issue_valid, issue_pc, issue_target, issue_is_jump, issue_pred_taken,
           cmp_result, flush, redirect_ready,
    input  issue_ready, redirect_valid, redirect_pc, resolved_valid, resolved_taken,
           branch_count, mispredict_count
  );

  modport slave (
    input  issue_valid, issue_pc, issue_target, issue_is_jump, issue_pred_taken,
           cmp_result, flush, redirect_ready,
    output issue_ready, redirect_valid, redirect_pc, resolved_valid, resolved_taken,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/branch_resolve.sv
// Resolves a branch one cycle after issue using the registered comparator
// result; raises and holds a redirect on mispredict, keeps saturating stats.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave br
);
  br_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d, rpc_q, rpc_d;
  logic            jmp_q, jmp_d, pred_q, pred_d;
  logic            taken, mispredict, br_inc, mp_inc;
  logic [XLEN-1:0] next_pc;
  logic [CNT_W-1:0] br_cnt, mp_cnt;

  assign taken      = jmp_q | br.cmp_result;
  assign next_pc    = taken ? tgt_q : pc_q + XLEN'(PC_INC);
  assign mispredict = taken != pred_q;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    tgt_d             = tgt_q;
    jmp_d             = jmp_q;
    pred_d            = pred_q;
    rpc_d             = rpc_q;
    br.issue_ready    = 1'b0;
    br.resolved_valid = 1'b0;
    br.resolved_taken = 1'b0;
    br.redirect_valid = 1'b0;
    br_inc            = 1'b0;
    mp_inc            = 1'b0;
    case (state_q)
      IDLE: begin
        br.issue_ready = ~br.flush;
        if (br.issue_valid && !br.flush) begin
          pc_d    = br.issue_pc;
          tgt_d   = br.issue_target;
          jmp_d   = br.issue_is_jump;
          pred_d  = br.issue_pred_taken;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (br.flush) begin
          state_d = IDLE;
        end else begin
          br.resolved_valid = 1'b1;
          br.resolved_taken = taken;
          br_inc            = 1'b1;
          mp_inc            = mispredict;
          if (mispredict) begin
            rpc_d   = next_pc;
            state_d = REDIRECT;
          end else begin
            // Correct prediction frees the slot for a back-to-back issue.
            br.issue_ready = 1'b1;
            if (br.issue_valid) begin
              pc_d   = br.issue_pc;
              tgt_d  = br.issue_target;
              jmp_d  = br.issue_is_jump;
              pred_d = br.issue_pred_taken;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      REDIRECT: begin
        br.redirect_valid = ~br.flush;
        if (br.flush || br.redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      tgt_q   <= '0;
      jmp_q   <= 1'b0;
      pred_q  <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      jmp_q   <= jmp_d;
      pred_q  <= pred_d;
      rpc_q   <= rpc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (.clk(clk), .rst(rst), .inc(br_inc), .count(br_cnt));
  sat_counter #(.W(CNT_W)) u_mp_cnt (.clk(clk), .rst(rst), .inc(mp_inc), .count(mp_cnt));

  assign br.redirect_pc      = rpc_q;
  assign br.branch_count     = br_cnt;
  assign br.mispredict_count = mp_cnt;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: transaction-level model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_branch_resolve;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bif ();

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .br (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at most one branch in flight, at most one pending redirect.
  bit          m_inf = 0, m_jmp = 0, m_pred = 0, m_rpend = 0;
  logic [31:0] m_pc = 0, m_tgt = 0, m_rpc = 0;
  int          m_bc = 0, m_mc = 0;

  function automatic bit m_taken();
    return m_jmp | bif.cmp_result;
  endfunction
  function automatic bit m_mis();
    return m_inf && (m_taken() != m_pred);
  endfunction
  function automatic bit m_ready();
    return !bif.flush && !m_rpend && !m_mis();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_inf <= 0; m_rpend <= 0; m_rpc <= 0; m_bc <= 0; m_mc <= 0;
    end else begin
      if (m_inf && !bif.flush) begin
        m_bc <= (m_bc < CMAX) ? m_bc + 1 : CMAX;
        if (m_mis()) begin
          m_mc  <= (m_mc < CMAX) ? m_mc + 1 : CMAX;
          m_rpc <= m_taken() ? m_tgt : m_pc + 32'd4;
        end
      end
      if (bif.flush)                        m_rpend <= 0;
      else if (m_mis())                     m_rpend <= 1;
      else if (m_rpend && bif.redirect_ready) m_rpend <= 0;
      if (bif.issue_valid && m_ready()) begin
        m_inf <= 1; m_pc <= bif.issue_pc; m_tgt <= bif.issue_target;
        m_jmp <= bif.issue_is_jump; m_pred <= bif.issue_pred_taken;
      end else begin
        m_inf <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m.resolved_valid", bif.resolved_valid, m_inf && !bif.flush);
      chk("m.resolved_taken", bif.resolved_taken, m_inf && !bif.flush && m_taken());
      chk("m.issue_ready", bif.issue_ready, m_ready());
      chk("m.redirect_valid", bif.redirect_valid, m_rpend && !bif.flush);
      chk("m.redirect_pc", bif.redirect_pc, m_rpc);
      chk("m.branch_count", bif.branch_count, m_bc);
      chk("m.mispredict_count", bif.mispredict_count, m_mc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic jmp, input logic pred);
    bif.issue_valid      = v;
    bif.issue_pc         = pc;
    bif.issue_target     = tgt;
    bif.issue_is_jump    = jmp;
    bif.issue_pred_taken = pred;
  endtask

  initial begin
    iss(0, 0, 0, 0, 0);
    bif.cmp_result     = 0;
    bif.flush          = 0;
    bif.redirect_ready = 0;
    step(); step();
    rst = 0;
    #1;
    chk("rst.issue_ready", bif.issue_ready, 1);
    chk("rst.redirect_valid", bif.redirect_valid, 0);
    chk("rst.redirect_pc", bif.redirect_pc, 0);
    chk("rst.resolved_valid", bif.resolved_valid, 0);
    chk("rst.counts", {bif.branch_count, bif.mispredict_count}, 0);

    // Taken branch predicted not-taken
    step(); iss(1, 32'h1000, 32'h2000, 0, 0);
    step(); iss(0, 0, 0, 0, 0); bif.cmp_result = 1;
    #1 chk("t1.resolved_valid", bif.resolved_valid, 1);
    chk("t1.resolved_taken", bif.resolved_taken, 1);
    chk("t1.issue_ready", bif.issue_ready, 0);
    step(); bif.cmp_result = 0; bif.redirect_ready = 1;
    #1 chk("t1.redirect_valid", bif.redirect_valid, 1);
    chk("t1.redirect_pc", bif.redirect_pc, 32'h2000);
    chk("t1.mispredict_count", bif.mispredict_count, 1);
    step(); bif.redirect_ready = 0;
    #1 chk("t1.redirect_drop", bif.redirect_valid, 0);

    // Correct not-taken, then back-to-back correct taken
    step(); iss(1, 32'h1000, 32'h5000, 0, 0);
    step(); iss(1, 32'h1004, 32'h3000, 0, 1); bif.cmp_result = 0;
    #1 chk("t2.b2b_ready", bif.issue_ready, 1);
    chk("t2.taken0", bif.resolved_taken, 0);
    step(); iss(0, 0, 0, 0, 0); bif.cmp_result = 1;
    #1 chk("t2.no_redirect", bif.redirect_valid, 0);
    chk("t2.branch_count", bif.branch_count, 2);
    step(); bif.cmp_result = 0;
    #1 chk("t2.branch_count2", bif.branch_count, 3);
    chk("t2.mispredict_count", bif.mispredict_count, 1);

    // Jump at top of address space, redirect held 5 cycles
    step(); iss(1, 32'hFFFF_FFFC, 32'h40, 1, 0);
    step(); iss(0, 0, 0, 0, 0);
    #1 chk("t3.jump_taken", bif.resolved_taken, 1);
    repeat (5) begin
      step();
      #1 chk("t3.hold_pc", bif.redirect_pc, 32'h40);
      chk("t3.hold_valid", bif.redirect_valid, 1);
      chk("t3.hold_ready", bif.issue_ready, 0);
    end
    step(); bif.redirect_ready = 1;
    step(); bif.redirect_ready = 0;
    #1 chk("t3.idle_ready", bif.issue_ready, 1);
    chk("t3.counts", {bif.branch_count, bif.mispredict_count}, {8'd4, 8'd2});

    // Predicted-taken, actually not-taken: pc+4 wraps to zero
    step(); iss(1, 32'hFFFF_FFFC, 32'h80, 0, 1);
    step(); iss(0, 0, 0, 0, 0); bif.cmp_result = 0;
    step(); bif.redirect_ready = 1;
    #1 chk("t4.wrap_pc", bif.redirect_pc, 32'h0);
    chk("t4.counts", {bif.branch_count, bif.mispredict_count}, {8'd5, 8'd3});
    step(); bif.redirect_ready = 0;

    // Flush in RESOLVE discards the result
    step(); iss(1, 32'h100, 32'h200, 0, 0);
    step(); iss(0, 0, 0, 0, 0); bif.cmp_result = 1; bif.flush = 1;
    #1 chk("t5.no_resolve", bif.resolved_valid, 0);
    chk("t5.flush_ready", bif.issue_ready, 0);
    step(); bif.flush = 0; bif.cmp_result = 0;
    #1 chk("t5.counts", {bif.branch_count, bif.mispredict_count}, {8'd5, 8'd3});
    chk("t5.idle", bif.issue_ready, 1);

    // Reset during REDIRECT
    step(); iss(1, 32'h100, 32'h200, 1, 0);
    step(); iss(0, 0, 0, 0, 0);
    step();
    #1 chk("t6.in_redirect", bif.redirect_valid, 1);
    rst = 1;
    step(); rst = 0;
    #1 chk("t6.redirect_gone", bif.redirect_valid, 0);
    chk("t6.counts", {bif.branch_count, bif.mispredict_count}, 0);

    // Reset and flush together in RESOLVE
    step(); iss(1, 32'h100, 32'h200, 0, 0);
    step(); iss(0, 0, 0, 0, 0); bif.cmp_result = 1; rst = 1; bif.flush = 1;
    step(); rst = 0; bif.flush = 0; bif.cmp_result = 0;
    #1 chk("t7.counts", {bif.branch_count, bif.mispredict_count}, 0);
    chk("t7.redirect", bif.redirect_valid, 0);

    // Saturation: CMAX mispredicts, then one more
    repeat (CMAX + 1) begin
      step(); iss(1, 32'h10, 32'h20, 0, 0);
      step(); iss(0, 0, 0, 0, 0); bif.cmp_result = 1;
      step(); bif.cmp_result = 0; bif.redirect_ready = 1;
      step(); bif.redirect_ready = 0;
    end
    #1 chk("t8.sat_branch", bif.branch_count, 8'hFF);
    chk("t8.sat_mispredict", bif.mispredict_count, 8'hFF);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage sitting directly downstream of the registered comparator unit in the execute stage. It accepts a branch/jump issue, consumes the comparator's registered `result` one cycle later, and decides the actual direction and next PC. On a misprediction it raises a redirect to fetch and holds it until accepted. It also keeps saturating branch and mispredict statistics counters.

## Interface
- `XLEN`, 32, PC/target width
- `CNT_W`, 16, statistics counter width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `issue_valid`  in  1  branch/jump presented this cycle (comparator gets its operands in the same cycle)
- `issue_ready`  out  1  block can accept an issue
- `issue_pc`  in  XLEN  PC of the branch
- `issue_target`  in  XLEN  computed taken target
- `issue_is_jump`  in  1  unconditional; ignore `cmp_result`
- `issue_pred_taken`  in  1  fetch's prediction
- `cmp_result`  in  1  comparator output, valid the cycle after issue acceptance
- `flush`  in  1  higher-priority pipeline flush (exception/trap)
- `redirect_valid`  out  1  fetch must restart at `redirect_pc`
- `redirect_ready`  in  1  fetch accepts redirect
- `redirect_pc`  out  XLEN  corrected next PC
- `resolved_valid`  out  1  one-cycle pulse: a branch resolved
- `resolved_taken`  out  1  actual direction for the pulse
- `branch_count`  out  CNT_W  resolved branches, saturating
- `mispredict_count`  out  CNT_W  mispredicts, saturating

## Operation
- States: IDLE, RESOLVE, REDIRECT.
- IDLE: `issue_ready`=1. On `issue_valid`, capture pc, target, is_jump, pred_taken, then go to RESOLVE.
- RESOLVE: taken = is_jump | cmp_result; next_pc = taken ? target : pc+4 (mod 2^XLEN, wrap silent); mispredict = taken != pred_taken.
  - Combinationally, `resolved_valid`=1 and `resolved_taken`=taken. Increment `branch_count`, and increment `mispredict_count` if mispredict.
  - No mispredict: `issue_ready`=1. A new issue this cycle is captured and the state stays RESOLVE; otherwise go to IDLE.
  - Mispredict: `issue_ready`=0. Register `redirect_pc`=next_pc and go to REDIRECT.
- REDIRECT: `redirect_valid`=1 and `redirect_pc` is held stable; `issue_ready`=0. On `redirect_ready`, go to IDLE.
- `flush` has priority in every state:
  - Next state is IDLE.
  - In RESOLVE, the result is discarded: no `resolved_valid`, no counter update.
  - In REDIRECT, the redirect is dropped.
  - An issue presented while `flush`=1 is not accepted, so `issue_ready`=0 when `flush`=1.
- Counters hold at all-ones and do not wrap.
- There is no alignment check on `issue_target`; alignment faults are handled elsewhere.

## Timing
- Issue accepted at cycle N. `cmp_result` is sampled and `resolved_valid` pulses at N+1. `redirect_valid` is first high at N+2.
- Counters show the updated value at N+2.
- Back-to-back correctly-predicted branches sustain one issue per cycle.
- Redirect handshake: the transfer occurs on a cycle with `redirect_valid` & `redirect_ready`. `redirect_valid` deasserts the following cycle.
- Reset values:
  - state IDLE
  - `redirect_valid`=0, `redirect_pc`=0
  - `resolved_valid`=0, `resolved_taken`=0
  - both counters 0
  - `issue_ready`=1 on the first cycle after reset deasserts
- `rst` mid-operation, including during REDIRECT, abandons everything at that edge. No redirect is emitted.
- Simultaneous `rst` and `flush`: `rst` wins; the result is identical.

## Structure
- Shared package `branch_pkg`: state enum `br_state_t` {IDLE, RESOLVE, REDIRECT}, constant `PC_INC`=4.
- One sub-module, `sat_counter`: parameter W, inputs `clk`/`rst`/`inc`, output `count`, saturating. Instantiated twice.

## Test plan
- Conditional branch, pc=0x1000, target=0x2000, pred_taken=0, cmp_result=1 -> `resolved_valid`/`resolved_taken`=1 at N+1; `redirect_valid`=1, `redirect_pc`=0x2000 at N+2; `mispredict_count`=1.
- Correct not-taken prediction, pc=0x1000, cmp_result=0, pred_taken=0 -> no redirect; `branch_count`=1; a second issue at N+1 is accepted.
- Jump with pc=0xFFFFFFFC, pred_taken=0, cmp_result=0 -> taken; `redirect_pc`=target. Separately, predicted-taken not-taken branch at pc=0xFFFFFFFC -> `redirect_pc`=0x00000000 (wrap).
- Redirect held with `redirect_ready`=0 for 5 cycles -> `redirect_pc` stable, `issue_ready`=0 throughout; `redirect_ready`=1 -> IDLE next cycle.
- `flush` asserted in RESOLVE -> no `resolved_valid`, counters unchanged, IDLE next. `rst` asserted during REDIRECT -> `redirect_valid`=0 next cycle, counters 0.
- Preload by driving 65535 mispredicts (or force), then one more -> both counters stay at 0xFFFF.
